// File: rtl/uart_rx_fifo_writer.sv
// UART 8N1 receiver with 16x oversampling that writes good bytes into a
// downstream receive FIFO (wr / w_data / fifo_full handshake).
// Frames with a bad stop bit raise frame_err; good bytes that arrive while
// the FIFO is full raise overrun_err. Neither case writes to the FIFO.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit. A parity mismatch is reported as frame_err.
module uart_rx_fifo_writer #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DVSR    = 54,
  parameter int unsigned DVSR_W  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            fifo_full,
  output logic            wr,
  output logic [DBIT-1:0] w_data,
  output logic            frame_err,
  output logic            overrun_err,
  output logic            busy
);

  // Width of the oversample tick counter; 16 ticks per bit need 4 bits.
  localparam int unsigned S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  // Width of the data bit counter.
  localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t              state_reg;
  state_t              state_next;
  logic [S_W-1:0]      s_reg;
  logic [S_W-1:0]      s_next;
  logic [N_W-1:0]      n_reg;
  logic [N_W-1:0]      n_next;
  logic [DBIT-1:0]     b_reg;
  logic [DBIT-1:0]     b_next;
  logic                armed_reg;
  logic                armed_next;
  logic                stop_eval;
  logic                parity_bad;

  logic [DVSR_W-1:0]   baud_reg;
  logic                tick;

  logic                rx_meta;
  logic                rx_s;

  logic                wr_next;
  logic                frame_err_next;
  logic                overrun_err_next;
  logic                busy_next;
  logic [DBIT-1:0]     w_data_next;

  // Two-flop synchroniser for the asynchronous RX pin; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running baud divider producing one oversample tick every DVSR clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_reg <= '0;
    end else if (baud_reg == DVSR_W'(DVSR - 1)) begin
      baud_reg <= '0;
    end else begin
      baud_reg <= baud_reg + DVSR_W'(1);
    end
  end

  assign tick = (baud_reg == DVSR_W'(DVSR - 1));

`ifdef UART_RX_PARITY_EN
  logic par_err_reg;
  logic par_err_next;

  // Sticky parity mismatch flag for the frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_reg <= 1'b0;
    end else begin
      par_err_reg <= par_err_next;
    end
  end

  assign parity_bad = par_err_reg;
`else
  assign parity_bad = 1'b0;
`endif

  // State register plus the frame datapath registers that move with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      armed_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      armed_reg <= armed_next;
    end
  end

  // Next-state logic: start detect, mid-bit sampling and stop evaluation.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    armed_next = armed_reg;
    stop_eval  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_next = par_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        // A high level must be seen after a frame error before re-arming,
        // so a held-low (break) line does not restart a frame.
        if (rx_s) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next = START;
          s_next     = '0;
`ifdef UART_RX_PARITY_EN
          par_err_next = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (s_reg == S_W'(7)) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              // Start bit no longer low at its centre: treat as a glitch.
              state_next = IDLE;
              s_next     = '0;
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == S_W'(15)) begin
            s_next = '0;
            b_next = {rx_s, b_reg[DBIT-1:1]};
            if (n_reg == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + N_W'(1);
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_reg == S_W'(15)) begin
            s_next     = '0;
            state_next = STOP;
            // Even parity: received parity bit must equal XOR of the data.
            par_err_next = rx_s ^ (^b_reg);
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_reg == S_W'(SB_TICK - 1)) begin
            state_next = IDLE;
            s_next     = '0;
            stop_eval  = 1'b1;
            if (!rx_s || parity_bad) begin
              armed_next = 1'b0;
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        s_next     = '0;
      end
    endcase
  end

  // Output decode: outcome of the stop evaluation, registered below.
  always_comb begin
    wr_next          = 1'b0;
    frame_err_next   = 1'b0;
    overrun_err_next = 1'b0;
    w_data_next      = w_data;
    busy_next        = (state_next != IDLE);
    if (stop_eval) begin
      if (!rx_s || parity_bad) begin
        frame_err_next = 1'b1;
      end else if (fifo_full) begin
        overrun_err_next = 1'b1;
        w_data_next      = b_reg;
      end else begin
        wr_next     = 1'b1;
        w_data_next = b_reg;
      end
    end
  end

  // Registered outputs; pulses last exactly one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr          <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
      w_data      <= '0;
    end else begin
      wr          <= wr_next;
      frame_err   <= frame_err_next;
      overrun_err <= overrun_err_next;
      busy        <= busy_next;
      w_data      <= w_data_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer with a fast baud divider (64 clk/bit).
module tb_uart_rx_fifo_writer;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       fifo_full;
  logic       wr;
  logic [7:0] w_data;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int wr_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int excl_viol = 0;
  int busy_viol = 0;
  logic busy_seen = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] wr_log[$];

  uart_rx_fifo_writer #(
    .DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .fifo_full(fifo_full),
    .wr(wr), .w_data(w_data), .frame_err(frame_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (wr) begin
        wr_cnt++;
        wr_log.push_back(w_data);
        if (busy || !prev_busy) busy_viol++;
        if (fifo_full) excl_viol++;
      end
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (int'(wr) + int'(frame_err) + int'(overrun_err) > 1) excl_viol++;
      if (busy) busy_seen = 1'b1;
    end
    prev_busy = busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    drive_bit(stop_v);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       full;
    logic       par_flip;
    int         exp_wr;
    int         exp_fe;
    int         exp_ov;
    logic [7:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int w0, f0, o0;
    vec_t v;

    rx = 1'b1;
    fifo_full = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_wr", 32'(wr), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    chk("reset_overrun_err", 32'(overrun_err), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_w_data", 32'(w_data), 0);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);

    // data, stop, full, par_flip, wr, fe, ov, w_data after the frame
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'hA5});
    vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 0, 1, 0, 8'hA5});
    vecs.push_back('{8'h12, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'h12});
    vecs.push_back('{8'h7E, 1'b1, 1'b1, 1'b0, 0, 0, 1, 8'h7E});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'hFF});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 0, 1, 0, 8'hFF});
    vecs.push_back('{8'h81, 1'b1, 1'b1, 1'b1, 0, 1, 0, 8'hFF});
`endif

    foreach (vecs[k]) begin
      v = vecs[k];
      fifo_full = v.full;
      w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(v.data, v.stop_v, v.par_flip);
      repeat (2 * BIT_CLK) @(negedge clk);
      chk($sformatf("vec%0d_wr", k), 32'(wr_cnt - w0), 32'(v.exp_wr));
      chk($sformatf("vec%0d_frame_err", k), 32'(fe_cnt - f0), 32'(v.exp_fe));
      chk($sformatf("vec%0d_overrun_err", k), 32'(ov_cnt - o0), 32'(v.exp_ov));
      chk($sformatf("vec%0d_w_data", k), 32'(w_data), 32'(v.exp_wdata));
      chk($sformatf("vec%0d_busy_idle", k), 32'(busy), 0);
      fifo_full = 1'b0;
    end

    // Back-to-back frames with no idle time between them.
    w0 = wr_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("b2b_wr_count", 32'(wr_cnt - w0), 2);
    if (wr_log.size() >= 2) begin
      chk("b2b_first", 32'(wr_log[wr_log.size()-2]), 32'h3C);
      chk("b2b_second", 32'(wr_log[wr_log.size()-1]), 32'hC3);
    end else begin
      chk("b2b_log_size", 32'(wr_log.size()), 2);
    end

    // Short low glitch: START entered, then aborted with no pulses.
    w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("glitch_busy_seen", 32'(busy_seen), 1);
    chk("glitch_pulses", 32'((wr_cnt - w0) + (fe_cnt - f0) + (ov_cnt - o0)), 0);
    chk("glitch_busy_idle", 32'(busy), 0);

    // Break: line held low for 20 bit times, then a normal frame.
    w0 = wr_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    chk("break_frame_err", 32'(fe_cnt - f0), 1);
    chk("break_no_wr", 32'(wr_cnt - w0), 0);
    chk("break_busy_low", 32'(busy), 0);
    chk("break_w_data_kept", 32'(w_data), 32'hC3);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    send_frame(8'h34, 1'b1, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("after_break_wr", 32'(wr_cnt - w0), 1);
    chk("after_break_w_data", 32'(w_data), 32'h34);

    // Reset in the middle of the data bits, then a clean frame.
    w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_w_data", 32'(w_data), 0);
    chk("midreset_wr", 32'(wr), 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("postreset_wr", 32'(wr_cnt - w0), 1);
    chk("postreset_errs", 32'((fe_cnt - f0) + (ov_cnt - o0)), 0);
    chk("postreset_w_data", 32'(w_data), 32'h81);

    chk("pulse_exclusive", 32'(excl_viol), 0);
    chk("busy_falls_with_wr", 32'(busy_viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
